// File: rtl/io_defs.sv
// Shared definitions for the buffered byte I/O unit: opcode decode and IN state encoding.
package io_defs;

  localparam logic [2:0] OP_IO  = 3'b011;
  localparam int         OPB_IN = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } io_state_e;

  function automatic logic is_io_op(input logic [5:0] ope);
    return ope[2:0] == OP_IO;
  endfunction

endpackage

// File: rtl/io_fifo_unit_if.sv
// Issue, write-back and byte-stream handshake bundle of the buffered I/O unit.
interface io_fifo_unit_if #(
  parameter int DATA_W = 8,
  parameter int WORD_W = 32,
  parameter int REG_W  = 6
);

  logic [5:0]        ope;
  logic [WORD_W-1:0] ds_val;
  logic [REG_W-1:0]  dd;
  logic [6:0]        is_busy;
  logic [REG_W-1:0]  io_addr;
  logic [WORD_W-1:0] io_dd_val;
  logic [DATA_W-1:0] io_in_data;
  logic              io_in_vld;
  logic              io_in_rdy;
  logic [DATA_W-1:0] io_out_data;
  logic              io_out_vld;
  logic              io_out_rdy;

  modport master (
    output ope, ds_val, dd, io_in_data, io_in_vld, io_out_rdy,
    input  is_busy, io_addr, io_dd_val, io_in_rdy, io_out_data, io_out_vld
  );

  modport slave (
    input  ope, ds_val, dd, io_in_data, io_in_vld, io_out_rdy,
    output is_busy, io_addr, io_dd_val, io_in_rdy, io_out_data, io_out_vld
  );

endinterface

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with count, full/empty flags and a zero-when-empty head view.
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/io_fifo_unit.sv
// Buffered execution-stage IN/OUT unit with input/output byte FIFOs and one-cycle write-back.
// Define IO_IN_BYPASS_EN to forward a byte arriving during WAIT straight to write-back.
//
// state | meaning
// IDLE  | accepting IO ops; IN with a buffered byte completes immediately
// WAIT  | IN issued on an empty input FIFO; holding its destination until a byte arrives
module io_fifo_unit
  import io_defs::*;
#(
  parameter int DATA_W    = 8,
  parameter int WORD_W    = 32,
  parameter int REG_W     = 6,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rstn,
  io_fifo_unit_if.slave  bus
);

  io_state_e         state_q, state_d;
  logic [REG_W-1:0]  dd_q, dd_d;
  logic [REG_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0] dd_val_q, dd_val_d;

  logic              io_busy, io_op;
  logic              bypass_take;
  logic              in_push, in_pop, in_full, in_empty;
  logic              out_push, out_pop, out_full, out_empty;
  logic [DATA_W-1:0] in_head, out_head;
  logic [$clog2(IN_DEPTH):0]  in_cnt;
  logic [$clog2(OUT_DEPTH):0] out_cnt;
  logic              unused_bits;

  // Busy never looks at ope, so the issuer can sample it before presenting an op.
  assign io_busy = out_full | (state_q == WAIT);
  assign io_op   = is_io_op(bus.ope) & ~io_busy;

  always_comb begin
    state_d     = state_q;
    dd_d        = dd_q;
    addr_d      = '0;
    dd_val_d    = dd_val_q;
    in_pop      = 1'b0;
    out_push    = 1'b0;
    bypass_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_op) begin
          if (bus.ope[OPB_IN]) begin
            if (!in_empty) begin
              in_pop   = 1'b1;
              addr_d   = bus.dd;
              dd_val_d = {{(WORD_W-DATA_W){1'b0}}, in_head};
            end else begin
              dd_d    = bus.dd;
              state_d = WAIT;
            end
          end else begin
            out_push = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!in_empty) begin
          in_pop   = 1'b1;
          addr_d   = dd_q;
          dd_val_d = {{(WORD_W-DATA_W){1'b0}}, in_head};
          state_d  = IDLE;
        end
`ifdef IO_IN_BYPASS_EN
        else if (bus.io_in_vld) begin
          bypass_take = 1'b1;
          addr_d      = dd_q;
          dd_val_d    = {{(WORD_W-DATA_W){1'b0}}, bus.io_in_data};
          state_d     = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      dd_q     <= '0;
      addr_q   <= '0;
      dd_val_q <= '0;
    end else begin
      state_q  <= state_d;
      dd_q     <= dd_d;
      addr_q   <= addr_d;
      dd_val_q <= dd_val_d;
    end
  end

  assign in_push = bus.io_in_vld & bus.io_in_rdy & ~bypass_take;
  assign out_pop = ~out_empty & bus.io_out_rdy;

  io_sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (in_push),
    .pop_i   (in_pop),
    .din_i   (bus.io_in_data),
    .head_o  (in_head),
    .full_o  (in_full),
    .empty_o (in_empty),
    .count_o (in_cnt)
  );

  io_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (out_push),
    .pop_i   (out_pop),
    .din_i   (bus.ds_val[DATA_W-1:0]),
    .head_o  (out_head),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_cnt)
  );

  assign bus.io_in_rdy   = ~in_full;
  assign bus.io_out_vld  = ~out_empty;
  assign bus.io_out_data = out_head;
  assign bus.is_busy     = {6'b0, io_busy};
  assign bus.io_addr     = addr_q;
  assign bus.io_dd_val   = dd_val_q;

  assign unused_bits = ^{in_cnt, out_cnt, bus.ope[5:4], bus.ds_val[WORD_W-1:DATA_W]};

endmodule

// File: tb/tb_io_fifo_unit.sv
// Directed scoreboard bench for io_fifo_unit: OUT ordering, IN write-back timing, busy and reset.
module tb_io_fifo_unit;
  import io_defs::*;

  localparam int DATA_W = 8;
  localparam int WORD_W = 32;
  localparam int REG_W  = 6;
  localparam int WB_W   = REG_W + WORD_W;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] out_q [$];
  logic [WB_W-1:0]   wb_q  [$];

  io_fifo_unit_if #(.DATA_W(DATA_W), .WORD_W(WORD_W), .REG_W(REG_W)) bus ();

  io_fifo_unit #(
    .DATA_W(DATA_W), .WORD_W(WORD_W), .REG_W(REG_W), .IN_DEPTH(4), .OUT_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs just before each active edge: consumes scoreboard entries for what the DUT presents.
  task automatic monitor();
    if (bus.io_out_vld && bus.io_out_rdy) begin
      chk("out_expected", 64'(out_q.size() != 0), 64'd1);
      if (out_q.size() != 0) chk("out_byte", 64'(bus.io_out_data), 64'(out_q.pop_front()));
    end
    if (bus.io_addr != '0) begin
      chk("wb_expected", 64'(wb_q.size() != 0), 64'd1);
      if (wb_q.size() != 0) chk("wb_value", 64'({bus.io_addr, bus.io_dd_val}), 64'(wb_q.pop_front()));
    end
  endtask

  task automatic cyc();
    #1;
    monitor();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_out(input logic [DATA_W-1:0] b);
    chk("out_issue_not_busy", 64'(bus.is_busy), 64'd0);
    bus.ope    = {3'b000, OP_IO};
    bus.ds_val = {24'hABCDEF, b};
    out_q.push_back(b);
    cyc();
    bus.ope    = '0;
    bus.ds_val = '0;
  endtask

  task automatic do_in(input logic [REG_W-1:0] d, input logic [DATA_W-1:0] b, input bit exp_wb);
    chk("in_issue_not_busy", 64'(bus.is_busy), 64'd0);
    bus.ope = {3'b001, OP_IO};
    bus.dd  = d;
    if (exp_wb) wb_q.push_back({d, {(WORD_W-DATA_W){1'b0}}, b});
    cyc();
    bus.ope = '0;
    bus.dd  = '0;
  endtask

  initial begin
    bus.ope        = '0;
    bus.ds_val     = '0;
    bus.dd         = '0;
    bus.io_in_data = '0;
    bus.io_in_vld  = 1'b0;
    bus.io_out_rdy = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_busy",     64'(bus.is_busy),     64'd0);
    chk("rst_addr",     64'(bus.io_addr),     64'd0);
    chk("rst_dd_val",   64'(bus.io_dd_val),   64'd0);
    chk("rst_in_rdy",   64'(bus.io_in_rdy),   64'd1);
    chk("rst_out_vld",  64'(bus.io_out_vld),  64'd0);
    chk("rst_out_data", 64'(bus.io_out_data), 64'd0);
    rstn = 1'b1;

    // OUT pair drained straight through
    bus.io_out_rdy = 1'b1;
    do_out(8'h41);
    do_out(8'h42);
    chk("t1_head", 64'(bus.io_out_data), 64'h42);
    chk("t1_vld",  64'(bus.io_out_vld),  64'd1);
    chk("t1_busy", 64'(bus.is_busy),     64'd0);
    cyc();
    chk("t1_vld_drop", 64'(bus.io_out_vld), 64'd0);
    chk("t1_busy_end", 64'(bus.is_busy),    64'd0);

    // out FIFO fills, busy until downstream drains one
    bus.io_out_rdy = 1'b0;
    do_out(8'h10);
    do_out(8'h11);
    do_out(8'h12);
    do_out(8'h13);
    chk("t2_busy_full", 64'(bus.is_busy), 64'd1);
    cyc();
    chk("t2_busy_hold", 64'(bus.is_busy), 64'd1);
    bus.io_out_rdy = 1'b1;
    cyc();
    chk("t2_busy_clear", 64'(bus.is_busy), 64'd0);
    repeat (3) cyc();
    chk("t2_drained", 64'(bus.io_out_vld), 64'd0);

    // IN with a buffered byte
    bus.io_in_vld  = 1'b1;
    bus.io_in_data = 8'h7F;
    cyc();
    bus.io_in_vld  = 1'b0;
    bus.io_in_data = '0;
    do_in(6'd5, 8'h7F, 1'b1);
    chk("t3_addr",      64'(bus.io_addr),   64'd5);
    chk("t3_data",      64'(bus.io_dd_val), 64'h7F);
    cyc();
    chk("t3_addr_clr",  64'(bus.io_addr),   64'd0);
    chk("t3_data_hold", 64'(bus.io_dd_val), 64'h7F);

    // IN on an empty FIFO waits for the byte
    do_in(6'd9, 8'hA5, 1'b1);
    chk("t4_busy", 64'(bus.is_busy), 64'd1);
    cyc();
    chk("t4_busy_hold", 64'(bus.is_busy), 64'd1);
    chk("t4_no_wb",     64'(bus.io_addr), 64'd0);
    bus.io_in_vld  = 1'b1;
    bus.io_in_data = 8'hA5;
    cyc();
    bus.io_in_vld  = 1'b0;
    bus.io_in_data = '0;
`ifndef IO_IN_BYPASS_EN
    chk("t4_addr_early", 64'(bus.io_addr), 64'd0);
    chk("t4_busy_early", 64'(bus.is_busy), 64'd1);
    cyc();
`endif
    chk("t4_addr", 64'(bus.io_addr),   64'd9);
    chk("t4_data", 64'(bus.io_dd_val), 64'hA5);
    chk("t4_busy_clear", 64'(bus.is_busy), 64'd0);
    cyc();
    chk("t4_addr_clr", 64'(bus.io_addr), 64'd0);

    // input FIFO full, IN frees a slot for a held fifth byte
    for (int i = 1; i <= 4; i++) begin
      bus.io_in_vld  = 1'b1;
      bus.io_in_data = 8'(i);
      cyc();
    end
    chk("t5_rdy_full", 64'(bus.io_in_rdy), 64'd0);
    bus.io_in_data = 8'h05;
    do_in(6'd3, 8'h01, 1'b1);
    chk("t5_rdy_freed", 64'(bus.io_in_rdy), 64'd1);
    chk("t5_addr",      64'(bus.io_addr),   64'd3);
    cyc();
    bus.io_in_vld  = 1'b0;
    bus.io_in_data = '0;
    chk("t5_fifth_taken", 64'(bus.io_in_rdy), 64'd0);
    do_in(6'd7,  8'h02, 1'b1);
    do_in(6'd8,  8'h03, 1'b1);
    do_in(6'd10, 8'h04, 1'b1);
    do_in(6'd11, 8'h05, 1'b1);
    cyc();
    chk("t5_rdy_empty", 64'(bus.io_in_rdy), 64'd1);
    chk("t5_wb_done",   64'(wb_q.size()),   64'd0);

    // dd=0 consumes a byte silently; next IN must then wait
    bus.io_out_rdy = 1'b0;
    do_out(8'h55);
    do_out(8'h56);
    bus.io_in_vld  = 1'b1;
    bus.io_in_data = 8'h3C;
    cyc();
    bus.io_in_vld  = 1'b0;
    bus.io_in_data = '0;
    do_in(6'd0, 8'h3C, 1'b0);
    chk("t7_addr_zero", 64'(bus.io_addr), 64'd0);
    chk("t7_not_busy",  64'(bus.is_busy), 64'd0);
    do_in(6'd12, 8'h00, 1'b0);
    chk("t7_consumed_wait", 64'(bus.is_busy),    64'd1);
    chk("t6_out_queued",    64'(bus.io_out_vld), 64'd1);

    // async reset mid-WAIT with output bytes buffered
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_out_vld", 64'(bus.io_out_vld), 64'd0);
    chk("t6_busy",    64'(bus.is_busy),    64'd0);
    chk("t6_addr",    64'(bus.io_addr),    64'd0);
    chk("t6_dd_val",  64'(bus.io_dd_val),  64'd0);
    chk("t6_in_rdy",  64'(bus.io_in_rdy),  64'd1);
    out_q.delete();
    wb_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    bus.io_out_rdy = 1'b1;
    bus.io_in_vld  = 1'b1;
    bus.io_in_data = 8'h77;
    cyc();
    bus.io_in_vld  = 1'b0;
    bus.io_in_data = '0;
    repeat (4) cyc();
    chk("t6_no_stale_wb", 64'(bus.io_addr),    64'd0);
    chk("t6_no_out",      64'(bus.io_out_vld), 64'd0);
    chk("t6_idle",        64'(bus.is_busy),    64'd0);
    chk("end_out_q",      64'(out_q.size()),   64'd0);
    chk("end_wb_q",       64'(wb_q.size()),    64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
